// File: rtl/spi_shift_master.sv
// SPI mode-0 master shift engine: one full-duplex, MSB-first DATA_W-bit frame per start pulse.
// Each SCLK half-period lasts clock_div+1 clk cycles; chip-select frames the whole transfer.
module spi_shift_master #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [DIV_W-1:0]  clock_div,
  output logic              busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] BIT_PENULT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD
  } state_t;

  state_t            state;
  logic [DATA_W-2:0] tx_rem;
  logic [DATA_W-1:0] rx_shift;
  logic [DIV_W-1:0]  div_latch;
  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              half_done;

  // The counter runs 0..div_latch, i.e. H = div_latch+1 cycles, and never passes the latch, so it cannot wrap.
  assign half_done = (div_cnt == div_latch);

  // The MSB is driven onto mosi at acceptance, so only the remaining bits are held in the shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      tx_rem    <= '0;
      rx_shift  <= '0;
      div_latch <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      rx_data   <= '0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SETUP;
            tx_rem    <= tx_data[DATA_W-2:0];
            div_latch <= clock_div;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            cs_n      <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= tx_data[DATA_W-1];
          end
        end

        SETUP: begin
          if (half_done) begin
            div_cnt  <= '0;
            state    <= SHIFT_HI;
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[DATA_W-2:0], miso};
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (half_done) begin
            div_cnt <= '0;
            state   <= SHIFT_LO;
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < BIT_PENULT) begin
              mosi   <= tx_rem[DATA_W-2];
              tx_rem <= tx_rem << 1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        SHIFT_LO: begin
          if (half_done) begin
            div_cnt <= '0;
            if (bit_cnt < BIT_LAST) begin
              state    <= SHIFT_HI;
              sclk     <= 1'b1;
              rx_shift <= {rx_shift[DATA_W-2:0], miso};
            end else begin
              state <= HOLD;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (half_done) begin
            div_cnt <= '0;
            state   <= IDLE;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            mosi    <= 1'b0;
            rx_data <= rx_shift;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
